// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, a one-deep output
// register to decode, and redirect handling that drains stale responses.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    output logic [31:0] fetch_count
);

    // state | meaning
    // REQ   | request outstanding at pc_q
    // HOLD  | instruction presented to decode, waiting for id_ready
    // DRAIN | stale request at drain_addr_q outstanding; its data is dropped
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [63:0] drain_addr_q;
    logic        if_valid_q;
    logic [31:0] if_instruction_q;
    logic [63:0] if_pc_q;
    logic [31:0] fetch_count_q;
    logic [63:0] redirect_tgt_d;

    assign redirect_tgt_d = redirect_pc & ~64'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= REQ;
            pc_q             <= RESET_PC;
            drain_addr_q     <= 64'h0;
            if_valid_q       <= 1'b0;
            if_instruction_q <= 32'h0;
            if_pc_q          <= 64'h0;
            fetch_count_q    <= 32'h0;
        end else begin
            case (state_q)
                REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt_d;
                        if (!imem_ack) begin
                            // Memory still owes us the old word; keep its address on the bus.
                            drain_addr_q <= pc_q;
                            state_q      <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        if_instruction_q <= imem_rdata;
                        if_pc_q          <= pc_q;
                        if_valid_q       <= 1'b1;
                        state_q          <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_tgt_d;
                        if_valid_q <= 1'b0;
                        state_q    <= REQ;
                    end else if (id_ready) begin
                        pc_q          <= pc_q + 64'd4;
                        if_valid_q    <= 1'b0;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        state_q       <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt_d;
                    end
                    if (imem_ack) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end

    assign imem_req       = !rst && (state_q != HOLD);
    assign imem_addr      = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign if_valid       = if_valid_q;
    assign if_instruction = if_instruction_q;
    assign if_pc          = if_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule
